div_hilo_ctrl: RTL
==================

# div_hilo_ctrl

Sequencer and HI/LO register bank between the multicycle control unit and the iterative divider. Accepts a one-cycle divide request and latches operands. Restarts the divider with a reset pulse, then a load strobe, and waits for completion or divide-by-zero. Writes the results into architectural HI/LO in MIPS order (HI = remainder, LO = quotient). Also services multiplier result capture and mthi/mtlo writes, and gives the control unit a stall signal.

## Interface
- MAX_CYCLES, 0, WAIT-state watchdog limit in cycles; 0 disables the watchdog.
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  divide request from control unit; sampled only in IDLE.
- RsIn  in  32  dividend (signed).
- RtIn  in  32  divisor (signed).
- MtHi, MtLo  in  1 each  write WriteData into HI or LO.
- WriteData  in  32  data for MtHi/MtLo.
- MultDone  in  1  multiplier result valid.
- MultHI, MultLO  in  32 each  multiplier result halves.
- DivDone, Div0  in  1 each  divider completion and zero-divisor flags.
- DivHI  in  32  divider quotient output.
- DivLO  in  32  divider remainder output.
- DivA, DivB  out  32 each  operands to divider.
- DivReset  out  1  active-high divider reset.
- DivCtrl  out  1  divider load strobe.
- HIOut, LOOut  out  32 each  architectural HI/LO registers.
- Busy  out  1  stall to control unit.
- Done  out  1  one-cycle completion pulse.
- DivZero, Timeout  out  1 each  one-cycle exception flags, coincident with Done.

## Operation
- States: IDLE, CLR, LOAD, WAIT, FIN.
- IDLE:
  - Start=1 latches RsIn/RtIn into operand registers and moves to CLR.
  - Start=0 stays in IDLE.
- CLR:
  - DivReset=1 for one cycle; this clears the divider's stale run flag, sign flags and DivDone.
  - Next state is LOAD.
- LOAD:
  - DivCtrl=1 for one cycle while DivA/DivB present the latched operands.
  - Next state is WAIT and the watchdog counter is cleared.
- WAIT:
  - Priority order: Div0 > DivDone > watchdog.
  - Div0=1: go to FIN with DivZero; HI/LO are unchanged.
  - DivDone=1: on that edge HI<=DivLO and LO<=DivHI (the divider's half order is swapped relative to MIPS); go to FIN.
  - MAX_CYCLES≠0 and counter==MAX_CYCLES-1: go to FIN with Timeout; HI/LO are unchanged; the divider is left as is because the next Start restarts it.
  - Otherwise the counter increments.
- FIN:
  - Done=1 for one cycle, DivZero/Timeout as recorded; next state is IDLE.
- Busy=1 in CLR, LOAD and WAIT; 0 in IDLE and FIN.
- HI/LO writes when Busy=0:
  - MultDone loads HI<=MultHI and LO<=MultLO; it has priority over MtHi/MtLo in the same cycle.
  - Otherwise MtHi and MtLo each write WriteData independently; both may fire in one cycle.
- MultDone, MtHi and MtLo are ignored while Busy=1. The control unit is stalled then, so this is a protocol error, not a queued event.
- Start in FIN is ignored; the control unit re-issues it after Done.
- Start together with MtHi/MtLo in IDLE: both take effect; the Mt write lands, then the divide result overwrites it.
- DivA/DivB hold the latched operands in every state; they are 0 after reset.
- DivReset = ~Reset OR (state==CLR), so the divider is reset along with this block.

## Timing
- Reset low at an edge puts the block in IDLE with HIOut=LOOut=0, DivA=DivB=0, DivCtrl=0, Busy=0, Done=0, DivZero=0, Timeout=0, counter=0. This applies mid-operation too: any in-flight divide is abandoned with no Done.
- Divide sequence (edge 0 samples Start):
  - Cycle 1 CLR, cycle 2 LOAD; the divider latches at the end of cycle 2.
  - Earliest Div0 is seen in cycle 4.
  - FIN follows the cycle in which DivDone/Div0 is sampled.
  - Total latency = 3 + (divider iterations) + 1 cycles; Busy rises in cycle 1.
- Done, DivZero and Timeout are registered Moore outputs, high exactly one cycle.
- HIOut/LOOut update on the edge entering FIN and are valid while Done=1.
- Mult/Mt writes take effect on the next edge with no added latency.

## Test plan
- RsIn=7, RtIn=3, Start pulse (real divider attached) -> Busy high from cycle 1, Done one cycle; LOOut=2, HIOut=1.
- RsIn=-7 (0xFFFFFFF9), RtIn=3 -> LOOut=0xFFFFFFFE, HIOut=0xFFFFFFFF. Back-to-back with a 7/-3 Start on the cycle after Done -> LOOut=0xFFFFFFFE, HIOut=0x00000001; no sign carry-over from the prior op.
- Preload HI=0xAAAA0000, LO=0x0000BBBB via MtHi/MtLo, then divide 5/0 -> Done and DivZero coincide, earliest 5 cycles after Start; HI/LO unchanged.
- MAX_CYCLES=8, RsIn=1000, RtIn=1 -> Timeout and Done coincide in the cycle after the 8th WAIT cycle; HI/LO unchanged. The next 9/4 divide gives LO=2, HI=1.
- MultDone with MultHI=0x12345678, MultLO=0x9ABCDEF0 plus MtHi=1 in the same idle cycle -> HI=0x12345678, LO=0x9ABCDEF0. The same MultDone while Busy -> HI/LO unchanged.
- Reset low during WAIT of 100/3 -> next cycle all outputs at reset values, DivReset=1, no Done. After release, 10/3 -> LO=3, HI=1.

Source files
------------

// File: rtl/div_hilo_ctrl_if.sv
// rtl/div_hilo_ctrl_if.sv - control-unit, divider and HI/LO signals of the divide sequencer
interface div_hilo_ctrl_if;
  logic        start;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] write_data;
  logic        mult_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        div_done;
  logic        div0;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_reset;
  logic        div_ctrl;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout;

  modport master (
    output start, rs, rt, mt_hi, mt_lo, write_data,
    output mult_done, mult_hi, mult_lo,
    output div_done, div0, div_hi, div_lo,
    input  div_a, div_b, div_reset, div_ctrl,
    input  hi, lo, busy, done, div_zero, timeout
  );

  modport slave (
    input  start, rs, rt, mt_hi, mt_lo, write_data,
    input  mult_done, mult_hi, mult_lo,
    input  div_done, div0, div_hi, div_lo,
    output div_a, div_b, div_reset, div_ctrl,
    output hi, lo, busy, done, div_zero, timeout
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// rtl/div_hilo_ctrl.sv - divider sequencer and architectural HI/LO register bank
module div_hilo_ctrl #(
  parameter int unsigned MAX_CYCLES = 0
) (
  input logic           clk,
  input logic           resetn,
  div_hilo_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, FIN} state_t;

  localparam logic [31:0] WD_LAST = 32'(MAX_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        zero_q;
  logic        tmo_q;
  logic        busy;
  logic        wd_hit;
  logic        in_wait;

  assign busy    = (state == CLR) || (state == LOAD) || (state == WAIT);
  assign in_wait = (state == WAIT);
  assign wd_hit  = (MAX_CYCLES != 0) && (cnt == WD_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CLR;
      CLR:     state_next = LOAD;
      LOAD:    state_next = WAIT;
      WAIT:    if (bus.div0 || bus.div_done || wd_hit) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      zero_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.start) begin
        op_a <= bus.rs;
        op_b <= bus.rt;
      end
      if (state == LOAD)
        cnt <= '0;
      else if (in_wait)
        cnt <= cnt + 32'd1;
      // Exception flags are captured on the edge into FIN, so they are high only in FIN.
      zero_q <= in_wait && bus.div0;
      tmo_q  <= in_wait && !bus.div0 && !bus.div_done && wd_hit;
      // The divider presents quotient on its HI and remainder on its LO; MIPS wants the reverse.
      if (in_wait && !bus.div0 && bus.div_done) begin
        hi_q <= bus.div_lo;
        lo_q <= bus.div_hi;
      end else if (!busy) begin
        if (bus.mult_done) begin
          hi_q <= bus.mult_hi;
          lo_q <= bus.mult_lo;
        end else begin
          if (bus.mt_hi) hi_q <= bus.write_data;
          if (bus.mt_lo) lo_q <= bus.write_data;
        end
      end
    end
  end

  assign bus.div_a     = op_a;
  assign bus.div_b     = op_b;
  assign bus.div_reset = !resetn || (state == CLR);
  assign bus.div_ctrl  = (state == LOAD);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy;
  assign bus.done      = (state == FIN);
  assign bus.div_zero  = zero_q;
  assign bus.timeout   = tmo_q;

endmodule
